// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide engine owning the architectural HI and LO registers.
// Build option: define FAST_MUL_EN for single-cycle MULT/MULTU; divides stay iterative.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {IDLE = 2'd0, PREP = 2'd1, ITER = 2'd2, FIX = 2'd3} state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   a_r, b_r, quo_r, rem_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CW-1:0]      cnt_r;
  logic               is_div_r, neg_res_r, neg_rem_r, div0_r;

  logic               is_mul_s, is_div_s, sgn_s, iter_go_s, div_ge_s;
  logic [WIDTH:0]     mul_sum_s, div_shift_s;
  logic [WIDTH-1:0]   div_diff_s, quo_fix_s, rem_fix_s;
  logic [2*WIDTH-1:0] prod_fix_s;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

`ifdef FAST_MUL_EN
  function automatic logic [2*WIDTH-1:0] fast_product(input logic [WIDTH-1:0] x,
                                                      input logic [WIDTH-1:0] y,
                                                      input logic sgn);
    logic [2*WIDTH-1:0] xe, ye;
    xe = {{WIDTH{sgn & x[WIDTH-1]}}, x};
    ye = {{WIDTH{sgn & y[WIDTH-1]}}, y};
    return xe * ye;
  endfunction

  assign iter_go_s = start & is_div_s;
`else
  assign iter_go_s = start & (is_mul_s | is_div_s);
`endif

  assign is_mul_s = (op[2:1] == 2'b00);
  assign is_div_s = (op[2:1] == 2'b01);
  assign sgn_s    = op[0];

  // Multiplier bits sit in the low half of acc_r and shift out as the product shifts in.
  assign mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, (acc_r[0] ? a_r : {WIDTH{1'b0}})};
  assign div_shift_s = {rem_r, quo_r[WIDTH-1]};
  assign div_ge_s    = (div_shift_s >= {1'b0, b_r});
  assign div_diff_s  = div_shift_s[WIDTH-1:0] - b_r;

  // Divide by zero leaves |rs| as remainder, which the dividend-sign fix turns back into rs.
  assign prod_fix_s = neg_res_r ? (~acc_r + 1'b1) : acc_r;
  assign quo_fix_s  = div0_r ? {WIDTH{1'b1}} : (neg_res_r ? (~quo_r + 1'b1) : quo_r);
  assign rem_fix_s  = neg_rem_r ? (~rem_r + 1'b1) : rem_r;

  // Control FSM, iteration datapath and the architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= {WIDTH{1'b0}};
      lo        <= {WIDTH{1'b0}};
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      quo_r     <= {WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      cnt_r     <= {CW{1'b0}};
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      div0_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (iter_go_s) begin
            a_r       <= abs_val(rs_data, sgn_s);
            b_r       <= abs_val(rt_data, sgn_s);
            is_div_r  <= op[1];
            neg_res_r <= sgn_s & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_rem_r <= sgn_s & rs_data[WIDTH-1];
            div0_r    <= (rt_data == {WIDTH{1'b0}});
            busy      <= 1'b1;
            state_r   <= PREP;
          end
`ifdef FAST_MUL_EN
          else if (start && is_mul_s) begin
            {hi, lo} <= fast_product(rs_data, rt_data, sgn_s);
            done     <= 1'b1;
          end
`endif
          else if (start && (op == OP_MTHI)) begin
            hi <= rs_data;
          end else if (start && (op == OP_MTLO)) begin
            lo <= rs_data;
          end
        end
        PREP: begin
          cnt_r   <= CW'(WIDTH);
          acc_r   <= {{WIDTH{1'b0}}, b_r};
          rem_r   <= {WIDTH{1'b0}};
          quo_r   <= a_r;
          state_r <= ITER;
        end
        ITER: begin
          if (is_div_r) begin
            rem_r <= div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], div_ge_s};
          end else begin
            acc_r <= {mul_sum_s, acc_r[WIDTH-1:1]};
          end
          cnt_r <= cnt_r - 1'b1;
          if (cnt_r == CW'(1)) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          if (is_div_r) begin
            hi <= rem_fix_s;
            lo <= quo_fix_s;
          end else begin
            {hi, lo} <= prod_fix_s;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes expected HI/LO, a negedge monitor pops on done.
module tb_mult_div_unit;
  localparam int W = 32;
`ifdef FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] rs_data, rt_data, hi, lo;
  logic         busy, done;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           start_cyc;
    int           lat;
    int           busy_cyc;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           busy_cnt = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, pre_hi = '0, pre_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural reference: plain 64-bit arithmetic on the instruction definitions.
  function automatic void ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] ch, input logic [31:0] cl,
                                    output logic [31:0] nh, output logic [31:0] nl);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    nh = ch;
    nl = cl;
    case (o)
      3'b000: begin p = {32'h0, a} * {32'h0, b}; {nh, nl} = p; end
      3'b001: begin p = sa * sb; {nh, nl} = p; end
      3'b010: if (b == 32'd0) begin nl = 32'hFFFF_FFFF; nh = a; end
              else begin nl = a / b; nh = a % b; end
      3'b011: if (b == 32'd0) begin nl = 32'hFFFF_FFFF; nh = a; end
              else begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; end
      3'b100: nh = a;
      3'b101: nl = a;
      default: ;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", {63'd0, done}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result_hi", hi, mon_e.hi);
          chk("result_lo", lo, mon_e.lo);
          chk("latency", cyc - mon_e.start_cyc, mon_e.lat);
          chk("busy_cycles", busy_cnt, mon_e.busy_cyc);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic pulse(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] nh, nl;
    exp_t ent;
    bit fast_op;
    ref_model(o, a, b, m_hi, m_lo, nh, nl);
    pre_hi = m_hi;
    pre_lo = m_lo;
    pulse(o, a, b);
    op = 3'($urandom); rs_data = $urandom; rt_data = $urandom;
    if (!o[2]) begin
      fast_op = FAST && !o[1];
      ent.hi = nh;
      ent.lo = nl;
      ent.start_cyc = cyc;
      ent.lat = fast_op ? 0 : W + 2;
      ent.busy_cyc = fast_op ? 0 : W + 2;
      exp_q.push_back(ent);
      chk("busy_after_start", {63'd0, busy}, fast_op ? 64'd0 : 64'd1);
    end
    m_hi = nh;
    m_lo = nl;
  endtask

  task automatic finish_op(input logic [2:0] o);
    bit stable = 1'b1;
    int n = 0;
    if (!o[2]) begin
      while (exp_q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
        if (busy && (hi !== pre_hi || lo !== pre_lo)) stable = 1'b0;
      end
      chk("op_timeout", exp_q.size(), 0);
      exp_q.delete();
      chk("hilo_stable_while_busy", {63'd0, stable}, 64'd1);
      @(negedge clk);
      chk("done_single_cycle", {63'd0, done}, 64'd0);
      chk("busy_after_done", {63'd0, busy}, 64'd0);
    end else begin
      @(negedge clk);
      chk("idle_op_hi", hi, m_hi);
      chk("idle_op_lo", lo, m_lo);
      chk("idle_op_busy", {63'd0, busy}, 64'd0);
      chk("idle_op_done", {63'd0, done}, 64'd0);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    launch(o, a, b);
    finish_op(o);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'b000; rs_data = '0; rt_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);

    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("t1_hi", hi, 32'hFFFF_FFFE);
    chk("t1_lo", lo, 32'h0000_0001);

    issue(3'b001, 32'hFFFF_FFFD, 32'd7);
    chk("t2_mult_hi", hi, 32'hFFFF_FFFF);
    chk("t2_mult_lo", lo, 32'hFFFF_FFEB);
    issue(3'b011, 32'hFFFF_FFF9, 32'd2);
    chk("t2_div_lo", lo, 32'hFFFF_FFFD);
    chk("t2_div_hi", hi, 32'hFFFF_FFFF);

    issue(3'b010, 32'd100, 32'd0);
    chk("t3_div0_lo", lo, 32'hFFFF_FFFF);
    chk("t3_div0_hi", hi, 32'h0000_0064);
    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("t3_ovf_lo", lo, 32'h8000_0000);
    chk("t3_ovf_hi", hi, 32'h0000_0000);

    issue(3'b100, 32'h1234_5678, 32'd0);
    chk("t4_mthi", hi, 32'h1234_5678);
    chk("t4_lo_kept", lo, 32'h8000_0000);
    launch(3'b010, 32'd50, 32'd7);
    repeat (3) @(posedge clk);
    pulse(3'b101, 32'hDEAD_BEEF, 32'd0);
    pulse(3'b000, 32'd9, 32'd9);
    finish_op(3'b010);
    chk("t4_lo", lo, 32'd7);
    chk("t4_hi", hi, 32'd1);

`ifndef FAST_MUL_EN
    // Abort a multiply at the 10th ITER edge (start edge + 11).
    pulse(3'b000, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("t5_reset_hi", hi, 0);
    chk("t5_reset_lo", lo, 0);
    chk("t5_reset_busy", {63'd0, busy}, 64'd0);
    chk("t5_reset_done", {63'd0, done}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    repeat (40) @(negedge clk);
    issue(3'b000, 32'd3, 32'd5);
    chk("t5_lo", lo, 32'd15);
    chk("t5_hi", hi, 32'd0);
`else
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("t6_hi", hi, 32'd0);
    chk("t6_lo", lo, 32'd1);
`endif

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Parametrised, multi-cycle HI/LO multiply/divide unit for the MIPS datapath. It replaces the combinational mult/div and HI/LO handling in the ALU with an iterative engine that owns the architectural HI and LO registers. The control unit issues an op with a start pulse. It stalls MFHI/MFLO while busy is high, and reads hi/lo directly.

Parameters:
WIDTH, 32, operand width in bits; hi and lo are each WIDTH bits; must be >= 4.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  op request; sampled on rising edge of clk.
op  input  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x NOP.
rs_data  input  WIDTH  multiplicand / dividend / MTHI-MTLO source.
rt_data  input  WIDTH  multiplier / divisor.
busy  output  1  high while an iterative op is in flight.
done  output  1  one-cycle pulse when hi/lo are updated by a mult/div.
hi  output  WIDTH  HI register (product upper half / remainder).
lo  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset: synchronous, active-high; the polarity and synchronicity are fixed. On reset, hi=0, lo=0, busy=0, done=0, and state=IDLE. Reset aborts any op in flight with no hi/lo write.
- States:
  - IDLE: start with a mult/div op moves to PREP at edge k. Operands are latched; signed ops latch absolute values and record the result signs.
  - PREP: next edge moves to ITER; the iteration counter is loaded with WIDTH.
  - ITER: exactly WIDTH edges. Mult uses shift-add on a 2*WIDTH accumulator. Div uses restoring shift-subtract on a (WIDTH+1)-bit partial remainder. Then moves to FIX.
  - FIX: sign correction; writes hi/lo; returns to IDLE.
- Timing: busy is 1 from edge k through the FIX edge. done is 1 for exactly the one cycle after the FIX edge, and hi/lo hold the new values in that same cycle. Latency from the start edge to done is WIDTH+2 edges.
- start while busy=1: ignored; the request is not queued.
- MTHI/MTLO in IDLE: hi (or lo) is set to rs_data at the sampling edge. No busy, no done, and the other register is unchanged.
- MTHI/MTLO while busy: ignored.
- NOP op: no effect.
- MULTU/MULT result: {hi,lo} is the full 2*WIDTH product; MULT is two's-complement.
- DIVU/DIV result: lo=quotient, hi=remainder.
  - DIV quotient truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero (rt_data=0), both signed and unsigned: lo = all ones, hi = rs_data. No trap.
- Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
- hi/lo change only on MTHI/MTLO, the FIX edge, or reset. They are stable otherwise, including throughout ITER.
- Operand inputs may change after the start edge without affecting the result.

Optional Feature:
FAST_MUL_EN
- Defined: MULT/MULTU use a single-cycle array multiply. hi/lo are written at the start edge and done pulses in the following cycle. busy stays 0 for multiplies. DIV/DIVU are unchanged.
- Undefined: all mult/div ops take the iterative WIDTH+2 path above.

Test Plan:
1. WIDTH=32, MULTU, rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done pulses 34 edges after start, and busy is high for 34 cycles (FAST_MUL_EN off).
2. MULT rs=0xFFFFFFFD (-3), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU rs=100, rt=0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MTHI rs=0x12345678 in IDLE -> hi=0x12345678 next cycle, lo unchanged, done=0. Start DIVU 50/7, then issue MTLO and MULTU while busy -> both ignored; final lo=7, hi=1.
5. Start MULTU 3*5, assert reset at edge 10 of ITER -> hi=lo=0, busy=0, and no done pulse. A new MULTU 3*5 then completes with lo=15, hi=0.
6. With FAST_MUL_EN defined, MULT rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0, lo=1 one cycle after start; busy never high.
